// File: rtl/ppbuf_rd_sched_pkg.sv
// rtl/ppbuf_rd_sched_pkg.sv - shared state encoding and default widths for the ping-pong read scheduler
package ppbuf_rd_sched_pkg;

  localparam int CNT_W_DEF  = 11;
  localparam int WAIT_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2,
    ST_STARVE  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/ppbuf_pace_cnt.sv
// rtl/ppbuf_pace_cnt.sv - read-slot pacing counter; one slot every ds_wait+1 clocks
module ppbuf_pace_cnt
  import ppbuf_rd_sched_pkg::*;
#(
  parameter int WAIT_W = WAIT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              hold,
  input  logic [WAIT_W-1:0] ds_wait,
  output logic              slot
);

  logic [WAIT_W-1:0] pace_q, pace_d;
  logic [WAIT_W-1:0] ds_wait_q, ds_wait_d;

  always_comb begin
    pace_d    = pace_q;
    ds_wait_d = ds_wait_q;
    if (clear) begin
      pace_d    = '0;
      ds_wait_d = ds_wait;
    end else if (pace_q == '0) begin
      // A consumed slot starts the next period and samples the new pacing value.
      if (!hold) begin
        pace_d    = (ds_wait_q == '0) ? '0 : WAIT_W'(1);
        ds_wait_d = ds_wait;
      end
    end else if (pace_q >= ds_wait_q) begin
      pace_d = '0;
    end else begin
      pace_d = pace_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pace_q    <= '0;
      ds_wait_q <= '0;
    end else begin
      pace_q    <= pace_d;
      ds_wait_q <= ds_wait_d;
    end
  end

  assign slot = (pace_q == '0);

endmodule

// File: rtl/ppbuf_rd_sched.sv
// rtl/ppbuf_rd_sched.sv - prefill/pace/starve read scheduler for the ping-pong sample FIFO
module ppbuf_rd_sched
  import ppbuf_rd_sched_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int WAIT_W      = WAIT_W_DEF,
  parameter int PREFILL_LVL = 512
) (
  input  logic              ACLK,
  input  logic              ARST,
  input  logic              enable,
  input  logic [WAIT_W-1:0] ds_wait,
  input  logic [CNT_W-1:0]  data_count,
  input  logic              buf_rready,
  input  logic              pwm_wready,
  output logic              buf_rd,
  output logic              mute,
  output logic              underrun,
  input  logic              underrun_clr,
  output logic [1:0]        sched_state
);

  sched_state_e state_q, state_d;
  logic buf_rd_q, buf_rd_d;
  logic mute_q, mute_d;
  logic underrun_q, underrun_d;
  logic slot, pace_clear, fire, underrun_set;

  always_comb begin
    state_d      = state_q;
    fire         = 1'b0;
    pace_clear   = 1'b0;
    underrun_set = 1'b0;
    if (!enable) begin
      state_d    = ST_IDLE;
      pace_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_PREFILL;
        ST_PREFILL: begin
          if (data_count >= CNT_W'(PREFILL_LVL)) begin
            state_d    = ST_RUN;
            pace_clear = 1'b1;
          end
        end
        ST_RUN: begin
          // A slot waits for the PWM side; only an empty FIFO at a live slot is starvation.
          if (slot && pwm_wready) begin
            if (buf_rready) begin
              fire = 1'b1;
            end else begin
              state_d      = ST_STARVE;
              underrun_set = 1'b1;
            end
          end
        end
        ST_STARVE:  state_d = ST_PREFILL;
        default:    state_d = ST_IDLE;
      endcase
    end
    buf_rd_d   = fire;
    mute_d     = (state_d != ST_RUN);
    underrun_d = underrun_set ? 1'b1 : (underrun_clr ? 1'b0 : underrun_q);
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q    <= ST_IDLE;
      buf_rd_q   <= 1'b0;
      mute_q     <= 1'b1;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_rd_q   <= buf_rd_d;
      mute_q     <= mute_d;
      underrun_q <= underrun_d;
    end
  end

  ppbuf_pace_cnt #(.WAIT_W(WAIT_W)) u_pace (
    .clk     (ACLK),
    .rst     (ARST),
    .clear   (pace_clear),
    .hold    (!fire),
    .ds_wait (ds_wait),
    .slot    (slot)
  );

  assign buf_rd      = buf_rd_q;
  assign mute        = mute_q;
  assign underrun    = underrun_q;
  assign sched_state = state_q;

endmodule
